store_align_unit: RTL

- Parametrised successor to the combinational store aligner: sequential store-path engine between the LSU and the data-memory bus.
- Accepts one store request per handshake and lane-aligns data and byte enables for XLEN of 32 or 64.
- Splits misaligned stores that cross a bus-word boundary into two bus beats, or raises a fault when splitting is disabled.
- Applies valid/ready backpressure on both sides; completion reported with a one-cycle done pulse.

---
 rtl/store_align_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/store_align_unit.sv
// Sequential store aligner between the LSU and the data-memory bus.
// Lane-aligns store data and byte enables; splits or faults stores that cross a bus word.
module store_align_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MISALIGN_SPLIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [1:0]          req_size,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic [XLEN-1:0]     bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_be,
    output logic                done,
    output logic                fault
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FAULT} state_t;

    state_t            state, state_next;
    logic [NB-1:0]     base_mask;
    logic [XLEN-1:0]   data_m;
    logic [OFFW-1:0]   off;
    logic [2*NB-1:0]   mask2;
    logic [2*XLEN-1:0] data2;
    logic              size_legal;
    logic              crosses;

    logic              req_ready_next;
    logic              bus_valid_next;
    logic [XLEN-1:0]   bus_addr_next;
    logic [XLEN-1:0]   bus_wdata_next;
    logic [NB-1:0]     bus_be_next;
    logic              done_next;
    logic              fault_next;
    logic [NB-1:0]     hi_be, hi_be_next;
    logic [XLEN-1:0]   hi_wdata, hi_wdata_next;

    // Request decode: a two-word-wide view of the shifted enables and data.
    always_comb begin
        off        = req_addr[OFFW-1:0];
        size_legal = 32'(req_size) <= OFFW;
        base_mask  = '0;
        data_m     = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            base_mask[i]     = i < (32'd1 << req_size);
            data_m[8*i +: 8] = base_mask[i] ? req_wdata[8*i +: 8] : 8'h00;
        end
        mask2   = (2*NB)'(base_mask) << off;
        data2   = (2*XLEN)'(data_m) << {off, 3'b000};
        crosses = |mask2[2*NB-1:NB];
    end

    // Next-state and registered-output values.
    always_comb begin
        state_next     = state;
        bus_valid_next = bus_valid;
        bus_addr_next  = bus_addr;
        bus_wdata_next = bus_wdata;
        bus_be_next    = bus_be;
        hi_be_next     = hi_be;
        hi_wdata_next  = hi_wdata;
        done_next      = 1'b0;
        fault_next     = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (!size_legal || (crosses && MISALIGN_SPLIT == 32'd0)) begin
                        state_next = FAULT;
                        done_next  = 1'b1;
                        fault_next = 1'b1;
                    end else begin
                        state_next     = BEAT0;
                        bus_valid_next = 1'b1;
                        bus_addr_next  = {req_addr[XLEN-1:OFFW], OFFW'(0)};
                        bus_be_next    = mask2[NB-1:0];
                        bus_wdata_next = data2[XLEN-1:0];
                        hi_be_next     = mask2[2*NB-1:NB];
                        hi_wdata_next  = data2[2*XLEN-1:XLEN];
                    end
                end
            end
            BEAT0: begin
                if (bus_ready) begin
                    if (|hi_be) begin
                        state_next     = BEAT1;
                        bus_addr_next  = bus_addr + XLEN'(NB);
                        bus_be_next    = hi_be;
                        bus_wdata_next = hi_wdata;
                    end else begin
                        state_next     = IDLE;
                        bus_valid_next = 1'b0;
                        done_next      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus_ready) begin
                    state_next     = IDLE;
                    bus_valid_next = 1'b0;
                    done_next      = 1'b1;
                end
            end
            FAULT: begin
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                bus_valid_next = 1'b0;
            end
        endcase

        req_ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            bus_valid <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            hi_be     <= '0;
            hi_wdata  <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            req_ready <= req_ready_next;
            bus_valid <= bus_valid_next;
            bus_addr  <= bus_addr_next;
            bus_wdata <= bus_wdata_next;
            bus_be    <= bus_be_next;
            hi_be     <= hi_be_next;
            hi_wdata  <= hi_wdata_next;
            done      <= done_next;
            fault     <= fault_next;
        end
    end

endmodule
